// File: rtl/clock_hours_counter_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared constants, display types and conversion helpers for the hours stage
// of the digital clock.
// -----------------------------------------------------------------------------
package clock_pkg;

  localparam int HOURS_PER_DAY = 24;
  localparam int HOUR_W        = 5;
  localparam int BCD_W         = 4;

  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] units;
  } bcd2_t;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;  // 1..12
    logic              pm;
  } hour12_t;

  typedef struct packed {
    bcd2_t digits;
    logic  pm;
  } disp_t;

  // Binary 0..23 to two BCD digits.
  function automatic bcd2_t bin_to_bcd2(input logic [HOUR_W-1:0] bin);
    bcd2_t r;
    if (bin >= HOUR_W'(20)) begin
      r.tens  = BCD_W'(2);
      r.units = BCD_W'(bin - HOUR_W'(20));
    end else if (bin >= HOUR_W'(10)) begin
      r.tens  = BCD_W'(1);
      r.units = BCD_W'(bin - HOUR_W'(10));
    end else begin
      r.tens  = '0;
      r.units = BCD_W'(bin);
    end
    return r;
  endfunction

  // 24 h value to 12 h clock face: 0 -> 12 am, 12 -> 12 pm.
  function automatic hour12_t hour_to_12h(input logic [HOUR_W-1:0] hour24);
    hour12_t r;
    r.pm = (hour24 >= HOUR_W'(12));
    if (hour24 == '0 || hour24 == HOUR_W'(12)) r.hour = HOUR_W'(12);
    else if (r.pm)                             r.hour = hour24 - HOUR_W'(12);
    else                                       r.hour = hour24;
    return r;
  endfunction

endpackage

// File: rtl/clock_hours_counter_if.sv
// -----------------------------------------------------------------------------
// clock_hours_counter_if
// Control inputs and display outputs of the hours stage.
//   master : drives set_mode, tick_in, key_inc, key_dec, mode_24
//   slave  : drives hour_bin, hrs_tens, hrs_units, pm, carry_out
// -----------------------------------------------------------------------------
interface clock_hours_counter_if;
  import clock_pkg::*;

  logic              set_mode;
  logic              tick_in;
  logic              key_inc;
  logic              key_dec;
  logic              mode_24;
  logic [HOUR_W-1:0] hour_bin;
  logic [BCD_W-1:0]  hrs_tens;
  logic [BCD_W-1:0]  hrs_units;
  logic              pm;
  logic              carry_out;

  modport master (
    output set_mode, tick_in, key_inc, key_dec, mode_24,
    input  hour_bin, hrs_tens, hrs_units, pm, carry_out
  );

  modport slave (
    input  set_mode, tick_in, key_inc, key_dec, mode_24,
    output hour_bin, hrs_tens, hrs_units, pm, carry_out
  );
endinterface

// File: rtl/clock_hours_counter_key_step_gen.sv
// -----------------------------------------------------------------------------
// key_step_gen
// Synchronises one raw key, detects its rising edge and, when REPEAT_CYCLES>0,
// produces repeat steps every REPEAT_CYCLES cycles while the key stays held.
//   clk, rst : clock, synchronous active-low reset
//   key_i    : raw asynchronous key level
//   clr_i    : disarm auto-repeat (run mode or both keys held)
//   step_o   : one-cycle step request (combinational from registered state)
//   level_o  : synchronised key level
// -----------------------------------------------------------------------------
module key_step_gen #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned REPEAT_CYCLES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  input  logic clr_i,
  output logic step_o,
  output logic level_o
);

  localparam int unsigned      CNT_W   = $clog2(REPEAT_CYCLES + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REPEAT_CYCLES);
  localparam bit               RPT_EN  = (REPEAT_CYCLES > 0);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rise;
  logic                   rpt;

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise    = level_o & ~prev_q;
  assign step_o  = rise | rpt;

  // cnt_q is zero while disarmed; it only arms on a genuine rising edge, so a
  // key already held when the counter is cleared never starts repeating.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], key_i};
    prev_d = level_o;
    cnt_d  = cnt_q;
    rpt    = 1'b0;
    if (!RPT_EN || clr_i || !level_o) begin
      cnt_d = '0;
    end else if (rise) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q == CNT_MAX) begin
      rpt   = 1'b1;
      cnt_d = CNT_W'(1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/clock_hours_counter.sv
// -----------------------------------------------------------------------------
// clock_hours_counter
// Hours stage of the digital clock: binary hour 0..23 advanced by the minutes
// carry in run mode, or stepped by inc/dec keys in set mode. Registered
// two-digit BCD display in 12 h or 24 h format plus a day-rollover pulse.
//   clk      : clock
//   rst      : synchronous reset, active-low
//   bus      : slave side of clock_hours_counter_if
//              (set_mode, tick_in, key_inc, key_dec, mode_24 in;
//               hour_bin, hrs_tens, hrs_units, pm, carry_out out)
// -----------------------------------------------------------------------------
module clock_hours_counter
  import clock_pkg::*;
#(
  parameter int unsigned RESET_HOUR      = 0,
  parameter int unsigned KEY_SYNC_STAGES = 2,
  parameter int unsigned REPEAT_CYCLES   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  clock_hours_counter_if.slave  bus
);

  if (RESET_HOUR >= HOURS_PER_DAY) begin : g_bad_reset_hour
    $error("clock_hours_counter: RESET_HOUR must be in 0..23");
  end
  if (KEY_SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("clock_hours_counter: KEY_SYNC_STAGES must be at least 2");
  end

  localparam logic [HOUR_W-1:0] LAST_HOUR = HOUR_W'(HOURS_PER_DAY - 1);
  localparam logic [HOUR_W-1:0] RST_HOUR  = HOUR_W'(RESET_HOUR);

  logic [HOUR_W-1:0] hour_q, hour_d;
  logic              carry_q, carry_d;
  disp_t             disp_q, disp_d;
  logic              inc_step, inc_lvl;
  logic              dec_step, dec_lvl;
  logic              key_clr;

  function automatic disp_t hour_display(input logic [HOUR_W-1:0] hour,
                                         input logic              mode24);
    disp_t   d;
    hour12_t h12;
    if (mode24) begin
      d.digits = bin_to_bcd2(hour);
      d.pm     = 1'b0;
    end else begin
      h12      = hour_to_12h(hour);
      d.digits = bin_to_bcd2(h12.hour);
      d.pm     = h12.pm;
    end
    return d;
  endfunction

  // Auto-repeat is only meaningful for a single held key in set mode.
  assign key_clr = ~bus.set_mode | (inc_lvl & dec_lvl);

  key_step_gen #(
    .SYNC_STAGES   (KEY_SYNC_STAGES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) u_inc (
    .clk     (clk),
    .rst     (rst),
    .key_i   (bus.key_inc),
    .clr_i   (key_clr),
    .step_o  (inc_step),
    .level_o (inc_lvl)
  );

  key_step_gen #(
    .SYNC_STAGES   (KEY_SYNC_STAGES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) u_dec (
    .clk     (clk),
    .rst     (rst),
    .key_i   (bus.key_dec),
    .clr_i   (key_clr),
    .step_o  (dec_step),
    .level_o (dec_lvl)
  );

  always_comb begin
    hour_d  = hour_q;
    carry_d = 1'b0;
    if (!rst) begin
      hour_d = RST_HOUR;
    end else if (!bus.set_mode) begin
      if (bus.tick_in) begin
        if (hour_q == LAST_HOUR) begin
          hour_d  = '0;
          carry_d = 1'b1;
        end else begin
          hour_d = hour_q + 1'b1;
        end
      end
    end else if (inc_step && !dec_step) begin
      hour_d = (hour_q == LAST_HOUR) ? '0 : hour_q + 1'b1;
    end else if (dec_step && !inc_step) begin
      hour_d = (hour_q == '0) ? LAST_HOUR : hour_q - 1'b1;
    end
    // Display is derived from the next hour so it lands on the same edge.
    disp_d = hour_display(hour_d, bus.mode_24);
  end

  always_ff @(posedge clk) begin
    hour_q  <= hour_d;
    carry_q <= carry_d;
    disp_q  <= disp_d;
  end

  assign bus.hour_bin  = hour_q;
  assign bus.carry_out = carry_q;
  assign bus.hrs_tens  = disp_q.digits.tens;
  assign bus.hrs_units = disp_q.digits.units;
  assign bus.pm        = disp_q.pm;

endmodule

// File: tb/tb_clock_hours_counter.sv
module tb_clock_hours_counter;

  localparam int RH = 0;
  localparam int S  = 2;
  localparam int R  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  clock_hours_counter_if bus();

  clock_hours_counter #(
    .RESET_HOUR      (RH),
    .KEY_SYNC_STAGES (S),
    .REPEAT_CYCLES   (R)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: hour as an integer, key levels as delayed raw samples,
  // repeat steps as "a multiple of R cycles since the press edge".
  int m_hour   = RH;
  int m_n      = 0;
  int m_edge_i = -1;
  int m_edge_d = -1;
  bit m_carry  = 1'b0;
  bit m_m24    = 1'b1;
  bit hist_i[0:S];
  bit hist_d[0:S];

  task automatic model_update();
    bit li, ld, ri, rd, clr, pi, pd;
    m_n++;
    m_m24 = bus.mode_24;
    if (!rst) begin
      m_hour = RH; m_carry = 1'b0; m_edge_i = -1; m_edge_d = -1;
      for (int j = 0; j <= S; j++) begin hist_i[j] = 1'b0; hist_d[j] = 1'b0; end
    end else begin
      li = hist_i[S-1]; ld = hist_d[S-1];
      ri = li && !hist_i[S]; rd = ld && !hist_d[S];
      clr = !bus.set_mode || (li && ld);
      pi = ri || (m_edge_i >= 0 && li && !clr && ((m_n - m_edge_i) % R == 0));
      pd = rd || (m_edge_d >= 0 && ld && !clr && ((m_n - m_edge_d) % R == 0));
      if (!li || clr) m_edge_i = -1; else if (ri) m_edge_i = m_n;
      if (!ld || clr) m_edge_d = -1; else if (rd) m_edge_d = m_n;
      m_carry = 1'b0;
      if (!bus.set_mode) begin
        if (bus.tick_in) begin
          if (m_hour == 23) begin m_hour = 0; m_carry = 1'b1; end
          else m_hour = m_hour + 1;
        end
      end else if (pi && !pd) m_hour = (m_hour + 1) % 24;
      else if (pd && !pi) m_hour = (m_hour + 23) % 24;
      for (int j = S; j > 0; j--) begin hist_i[j] = hist_i[j-1]; hist_d[j] = hist_d[j-1]; end
      hist_i[0] = bus.key_inc; hist_d[0] = bus.key_dec;
    end
  endtask

  // One clock: model follows the DUT edge, outputs are then sampled at negedge.
  task automatic cyc();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.mode_24 = 1'b1;
    cyc(); cyc();
    n_checks++;
    if ({bus.hour_bin, bus.hrs_tens, bus.hrs_units, bus.pm, bus.carry_out} !== {5'd0, 4'd0, 4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_24h: got hour=%0d disp=%0d%0d pm=%0b carry=%0b, expected 0 00 0 0",
               bus.hour_bin, bus.hrs_tens, bus.hrs_units, bus.pm, bus.carry_out);
    end
    bus.mode_24 = 1'b0;
    cyc();
    n_checks++;
    if ({bus.hour_bin, bus.hrs_tens, bus.hrs_units, bus.pm, bus.carry_out} !== {5'd0, 4'd1, 4'd2, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_12h: got hour=%0d disp=%0d%0d pm=%0b carry=%0b, expected 0 12 0 0",
               bus.hour_bin, bus.hrs_tens, bus.hrs_units, bus.pm, bus.carry_out);
    end
    rst = 1'b1; bus.mode_24 = 1'b1;
    cyc();
  endtask

  task automatic test_run_rollover();
    bus.tick_in = 1'b1;
    repeat (22) cyc();
    bus.tick_in = 1'b0;
    cyc();
    n_checks++;
    if (bus.hour_bin !== 5'd22) begin
      n_fail++; $display("FAIL run_to_22: got %0d expected 22", bus.hour_bin);
    end
    bus.tick_in = 1'b1; cyc(); bus.tick_in = 1'b0;
    n_checks++;
    if ({bus.hour_bin, bus.hrs_tens, bus.hrs_units, bus.carry_out} !== {5'd23, 4'd2, 4'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL run_23: got hour=%0d disp=%0d%0d carry=%0b expected 23 23 0",
               bus.hour_bin, bus.hrs_tens, bus.hrs_units, bus.carry_out);
    end
    bus.tick_in = 1'b1; cyc(); bus.tick_in = 1'b0;
    n_checks++;
    if ({bus.hour_bin, bus.hrs_tens, bus.hrs_units, bus.carry_out} !== {5'd0, 4'd0, 4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL run_wrap: got hour=%0d disp=%0d%0d carry=%0b expected 0 00 1",
               bus.hour_bin, bus.hrs_tens, bus.hrs_units, bus.carry_out);
    end
    cyc();
    n_checks++;
    if ({bus.hour_bin, bus.carry_out} !== {5'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL carry_one_cycle: got hour=%0d carry=%0b expected 0 0", bus.hour_bin, bus.carry_out);
    end
  endtask

  task automatic test_12h_sweep();
    int eh;
    bus.mode_24 = 1'b0;
    cyc();
    for (int i = 0; i < 24; i++) begin
      eh = (i % 12 == 0) ? 12 : i % 12;
      n_checks++;
      if ({bus.hour_bin, bus.hrs_tens, bus.hrs_units, bus.pm} !== {5'(i), 4'(eh / 10), 4'(eh % 10), (i >= 12)}) begin
        n_fail++;
        $display("FAIL sweep_12h[%0d]: got hour=%0d disp=%0d%0d pm=%0b expected %0d %0d%0d %0b",
                 i, bus.hour_bin, bus.hrs_tens, bus.hrs_units, bus.pm, i, eh / 10, eh % 10, i >= 12);
      end
      if (i == 15) begin
        bus.mode_24 = 1'b1; cyc();
        n_checks++;
        if ({bus.hour_bin, bus.hrs_tens, bus.hrs_units, bus.pm} !== {5'd15, 4'd1, 4'd5, 1'b0}) begin
          n_fail++;
          $display("FAIL mode_toggle: got hour=%0d disp=%0d%0d pm=%0b expected 15 15 0",
                   bus.hour_bin, bus.hrs_tens, bus.hrs_units, bus.pm);
        end
        bus.mode_24 = 1'b0; cyc();
      end
      bus.tick_in = 1'b1; cyc(); bus.tick_in = 1'b0;
    end
    bus.mode_24 = 1'b1;
    cyc();
  endtask

  task automatic test_set_keys();
    bus.set_mode = 1'b1; cyc();
    bus.key_dec = 1'b1; bus.tick_in = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      if (k == 2) bus.key_dec = 1'b0;
      n_checks++;
      if ({bus.hour_bin, bus.carry_out} !== {((k >= S + 1) ? 5'd23 : 5'd0), 1'b0}) begin
        n_fail++;
        $display("FAIL dec_step[%0d]: got hour=%0d carry=%0b expected %0d 0",
                 k, bus.hour_bin, bus.carry_out, (k >= S + 1) ? 23 : 0);
      end
    end
    bus.key_inc = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      if (k == 2) bus.key_inc = 1'b0;
      n_checks++;
      if ({bus.hour_bin, bus.carry_out} !== {((k >= S + 1) ? 5'd0 : 5'd23), 1'b0}) begin
        n_fail++;
        $display("FAIL inc_step[%0d]: got hour=%0d carry=%0b expected %0d 0",
                 k, bus.hour_bin, bus.carry_out, (k >= S + 1) ? 0 : 23);
      end
    end
    bus.tick_in = 1'b0;
    // Key held across entry into set mode must not step.
    bus.set_mode = 1'b0; cyc();
    bus.key_inc = 1'b1; repeat (4) cyc();
    bus.set_mode = 1'b1; repeat (10) cyc();
    bus.key_inc = 1'b0; repeat (4) cyc();
    n_checks++;
    if (bus.hour_bin !== 5'd0) begin
      n_fail++; $display("FAIL held_into_set: got %0d expected 0", bus.hour_bin);
    end
  endtask

  task automatic test_repeat();
    int exp_h;
    bus.set_mode = 1'b0; bus.tick_in = 1'b1;
    repeat (5) cyc();
    bus.tick_in = 1'b0; bus.set_mode = 1'b1;
    cyc();
    bus.key_inc = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (k == 14) bus.key_inc = 1'b0;
      exp_h = 5 + int'(k >= 3) + int'(k >= 7) + int'(k >= 11) + int'(k >= 15);
      n_checks++;
      if (bus.hour_bin !== 5'(exp_h)) begin
        n_fail++; $display("FAIL repeat[%0d]: got %0d expected %0d", k, bus.hour_bin, exp_h);
      end
    end
    bus.key_inc = 1'b1; bus.key_dec = 1'b1;
    repeat (12) cyc();
    bus.key_inc = 1'b0; bus.key_dec = 1'b0;
    repeat (4) cyc();
    n_checks++;
    if (bus.hour_bin !== 5'd9) begin
      n_fail++; $display("FAIL both_keys: got %0d expected 9", bus.hour_bin);
    end
  endtask

  task automatic test_reset_mid();
    bus.key_inc = 1'b1;
    repeat (8) cyc();
    n_checks++;
    if (bus.hour_bin !== 5'd11) begin
      n_fail++; $display("FAIL mid_repeat: got %0d expected 11", bus.hour_bin);
    end
    rst = 1'b0; bus.key_inc = 1'b0;
    cyc();
    n_checks++;
    if ({bus.hour_bin, bus.hrs_tens, bus.hrs_units, bus.carry_out} !== {5'd0, 4'd0, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_repeat: got hour=%0d disp=%0d%0d carry=%0b expected 0 00 0",
               bus.hour_bin, bus.hrs_tens, bus.hrs_units, bus.carry_out);
    end
    rst = 1'b1;
    repeat (10) cyc();
    n_checks++;
    if (bus.hour_bin !== 5'd0) begin
      n_fail++; $display("FAIL residual_step: got %0d expected 0", bus.hour_bin);
    end
    // Reset coinciding with the 23 -> 0 tick: no carry.
    bus.set_mode = 1'b0; bus.tick_in = 1'b1;
    repeat (23) cyc();
    rst = 1'b0;
    cyc();
    n_checks++;
    if ({bus.hour_bin, bus.carry_out} !== {5'd0, 1'b0}) begin
      n_fail++; $display("FAIL reset_on_carry: got hour=%0d carry=%0b expected 0 0", bus.hour_bin, bus.carry_out);
    end
    // Reset in the cycle after a carry clears it.
    rst = 1'b1;
    repeat (24) cyc();
    rst = 1'b0;
    cyc();
    n_checks++;
    if ({bus.hour_bin, bus.carry_out} !== {5'd0, 1'b0}) begin
      n_fail++; $display("FAIL reset_after_carry: got hour=%0d carry=%0b expected 0 0", bus.hour_bin, bus.carry_out);
    end
    rst = 1'b1; bus.tick_in = 1'b0;
    cyc();
  endtask

  task automatic test_random();
    int eh;
    bus.set_mode = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 39) == 0) bus.set_mode = ~bus.set_mode;
      bus.tick_in = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) bus.key_inc = ~bus.key_inc;
      if ($urandom_range(0, 6) == 0) bus.key_dec = ~bus.key_dec;
      if ($urandom_range(0, 15) == 0) bus.mode_24 = ~bus.mode_24;
      rst = ($urandom_range(0, 299) != 0);
      cyc();
      eh = m_m24 ? m_hour : ((m_hour % 12 == 0) ? 12 : m_hour % 12);
      n_checks++;
      if ({bus.hour_bin, bus.carry_out} !== {5'(m_hour), m_carry}) begin
        n_fail++;
        $display("FAIL rand_hour[%0d]: got hour=%0d carry=%0b expected %0d %0b",
                 c, bus.hour_bin, bus.carry_out, m_hour, m_carry);
      end
      n_checks++;
      if ({bus.hrs_tens, bus.hrs_units, bus.pm} !== {4'(eh / 10), 4'(eh % 10), (!m_m24 && m_hour >= 12)}) begin
        n_fail++;
        $display("FAIL rand_disp[%0d]: got %0d%0d pm=%0b expected %0d%0d pm=%0b",
                 c, bus.hrs_tens, bus.hrs_units, bus.pm, eh / 10, eh % 10, !m_m24 && m_hour >= 12);
      end
    end
  endtask

  initial begin
    bus.set_mode = 1'b0; bus.tick_in = 1'b0; bus.key_inc = 1'b0;
    bus.key_dec  = 1'b0; bus.mode_24 = 1'b1; rst = 1'b0;
    for (int j = 0; j <= S; j++) begin hist_i[j] = 1'b0; hist_d[j] = 1'b0; end
    test_reset();
    test_run_rollover();
    test_12h_sweep();
    test_set_keys();
    test_repeat();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_hours_counter.md
Name: clock_hours_counter

Overview:
Parametrised hours stage of the digital clock. It keeps the time-of-day hour in binary (0..23) and advances on the carry pulse from the minutes stage. It presents a registered two-digit BCD display in 12 h or 24 h format, selectable at run time, and emits a day carry. In set mode it accepts synchronised increment/decrement keys with edge detection and optional auto-repeat.

Parameters:
RESET_HOUR, 0, hour loaded on reset (0..23, binary 24 h value)
KEY_SYNC_STAGES, 2, flip-flop stages synchronising key_inc/key_dec (>=2)
REPEAT_CYCLES, 0, auto-repeat interval in clk cycles while a key is held; 0 disables auto-repeat

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
set_mode  in  1  1 = set mode (keys active, tick_in ignored); 0 = run mode
tick_in  in  1  one-cycle carry pulse from minutes stage
key_inc  in  1  raw increment key level, asynchronous
key_dec  in  1  raw decrement key level, asynchronous
mode_24  in  1  1 = 24 h display, 0 = 12 h display
hour_bin  out  5  current hour, binary 0..23
hrs_tens  out  4  BCD tens digit of displayed hour
hrs_units  out  4  BCD units digit of displayed hour
pm  out  1  12 h mode: 1 when hour_bin >= 12; forced 0 in 24 h mode
carry_out  out  1  one-cycle day-rollover pulse

Behaviour:
- All outputs registered. Display outputs reflect the hour on the same edge the hour changes (no extra latency).
- Reset (rst=0 at a posedge): hour_bin=RESET_HOUR; carry_out=0; key synchronisers, edge registers and repeat counter cleared; display digits/pm computed from RESET_HOUR and current mode_24. Reset overrides all other inputs, including mid-repeat.
- Run mode (set_mode=0):
  - tick_in=1: hour_bin+1. At 23, hour_bin wraps to 0 and carry_out=1 for exactly that cycle.
  - Keys are ignored, but synchronisers still track the key levels.
- Set mode (set_mode=1):
  - tick_in ignored; carry_out held 0.
  - A step is a rising edge of a synchronised key, seen KEY_SYNC_STAGES+1 cycles after the raw edge.
  - inc step: +1, 23 wraps to 0, no carry. dec step: -1, 0 wraps to 23.
  - Simultaneous inc and dec steps in one cycle: no change, and the repeat counter is cleared.
- Auto-repeat (REPEAT_CYCLES>0):
  - While exactly one synchronised key stays high after its edge step, a further step occurs every REPEAT_CYCLES cycles.
  - Releasing the key, pressing both keys, or leaving set mode clears the counter.
- set_mode transitions take effect on the next edge. A key held across entry into set mode produces no step until a fresh rising edge.
- Display mapping:
  - 24 h: digits = hour_bin in BCD (00..23).
  - 12 h: 0→12 with pm=0; 1..11→same with pm=0; 12→12 with pm=1; 13..23→hour-12 with pm=1.
  - Tens digit is always 0 or 1 in 12 h mode and 0..2 in 24 h mode. The 12 h display has a leading zero (e.g. 01).
- A mode_24 change alters only the display, one edge later. hour_bin is unaffected.
- Illegal RESET_HOUR (>23) is rejected by an elaboration-time check.

Decomposition:
- Shared package clock_pkg:
  - HOURS_PER_DAY=24, HOUR_W=5, BCD_W=4
  - function bin_to_bcd2 (0..23 to two BCD digits)
  - function hour_to_12h (returns hour 1..12 and pm flag)
- One sub-module, key_step_gen, instanced twice (inc, dec):
  - synchroniser, rising-edge detect, auto-repeat counter
  - outputs a one-cycle step pulse plus a held level, so the top can detect simultaneous presses.

Test Plan:
- Reset with RESET_HOUR=0, mode_24=1 → hour_bin=0, hrs=0/0, pm=0, carry_out=0. Same with mode_24=0 → hrs=1/2, pm=0.
- Run mode from hour 22, two tick_in pulses → hour 23 (2/3), then 0 (0/0) with carry_out=1 for exactly one cycle. No carry on the first pulse.
- mode_24=0 while sweeping all 24 hours via tick_in → display sequence 12,01..11 (pm=0), 12,01..11 (pm=1). hour_bin unchanged when mode_24 toggles mid-sweep.
- Set mode at hour 0: key_dec pulse → hour 23 with no carry, step appearing KEY_SYNC_STAGES+1 cycles after the raw edge. Then key_inc → 0. Concurrent tick_in pulses are ignored.
- REPEAT_CYCLES=4, set mode, key_inc held 14 cycles from hour 5 → steps at the edge and +4, +8, +12 cycles, ending at hour 9. Both keys pressed together → no change.
- Reset asserted mid-repeat and during a carry cycle → all state back to RESET_HOUR, carry_out=0 next cycle, no residual step after rst releases.
